// File: rtl/conv_acc_requant.sv
// rtl/conv_acc_requant.sv - accumulates channel partial sums, adds bias, requantises to INT8
// Define CONV_ACC_RELU_EN to clamp the output range to [0,127] instead of [-128,127].
module conv_acc_requant #(
  parameter int NUM_CH  = 3,
  parameter int ACC_W   = 32,
  parameter int OUT_PIX = 480,
  localparam int CH_W   = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
  localparam int PIX_W  = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    din_valid,
  input  logic signed [17:0]      din,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [4:0]       shift,
  output logic                    dout_valid,
  output logic signed [7:0]       dout,
  output logic                    frame_done,
  output logic        [CH_W-1:0]  ch_cnt,
  output logic        [PIX_W-1:0] pix_cnt
);

  localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0]        PIX_LAST = PIX_W'(OUT_PIX - 1);
  localparam logic signed [ACC_W:0]   SAT_HI   = (ACC_W+1)'(127);
`ifdef CONV_ACC_RELU_EN
  localparam logic signed [ACC_W:0]   SAT_LO   = '0;
`else
  localparam logic signed [ACC_W:0]   SAT_LO   = (ACC_W+1)'(-128);
`endif

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic        [CH_W-1:0]  ch_q, ch_d;
  logic        [PIX_W-1:0] pix_q, pix_d;
  logic        [4:0]       sh_q, sh_d;
  logic                    stb_q, stb_d;
  logic signed [7:0]       dout_q, dout_d;
  logic                    dval_q, dval_d;
  logic                    fd_q, fd_d;

  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   t;
  logic                    last_beat;

  always_comb begin
    din_ext   = ACC_W'(din);
    acc_sum   = acc_q + din_ext;
    last_beat = (ch_q == CH_LAST);
    // One extra bit of headroom so the half-LSB rounding add never wraps.
    sum_ext   = (ACC_W+1)'(sum_q);
    rnd       = (sh_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (sh_q - 5'd1));
    t         = (sum_ext + rnd) >>> sh_q;

    acc_d  = acc_q;
    ch_d   = ch_q;
    pix_d  = pix_q;
    sum_d  = sum_q;
    sh_d   = sh_q;
    stb_d  = 1'b0;
    dout_d = dout_q;
    dval_d = 1'b0;
    fd_d   = 1'b0;

    if (clear) begin
      acc_d = '0;
      ch_d  = '0;
      pix_d = '0;
    end else begin
      if (din_valid) begin
        if (last_beat) begin
          sum_d = acc_sum + bias;
          sh_d  = shift;
          acc_d = '0;
          ch_d  = '0;
          stb_d = 1'b1;
        end else begin
          acc_d = acc_sum;
          ch_d  = ch_q + CH_W'(1);
        end
      end
      if (stb_q) begin
        dval_d = 1'b1;
        fd_d   = (pix_q == PIX_LAST);
        pix_d  = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
        if (t > SAT_HI) begin
          dout_d = SAT_HI[7:0];
        end else if (t < SAT_LO) begin
          dout_d = SAT_LO[7:0];
        end else begin
          dout_d = t[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sum_q  <= '0;
      ch_q   <= '0;
      pix_q  <= '0;
      sh_q   <= '0;
      stb_q  <= 1'b0;
      dout_q <= '0;
      dval_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      ch_q   <= ch_d;
      pix_q  <= pix_d;
      sh_q   <= sh_d;
      stb_q  <= stb_d;
      dout_q <= dout_d;
      dval_q <= dval_d;
      fd_q   <= fd_d;
    end
  end

  assign dout_valid = dval_q;
  assign dout       = dout_q;
  assign frame_done = fd_q;
  assign ch_cnt     = ch_q;
  assign pix_cnt    = pix_q;

endmodule

// File: tb/tb_conv_acc_requant.sv
// tb/tb_conv_acc_requant.sv - directed and randomized checks of conv_acc_requant against a pixel-level model
// Expected negative saturation follows CONV_ACC_RELU_EN.
module tb_conv_acc_requant;

  localparam int NUM_CH  = 3;
  localparam int OUT_PIX = 480;

`ifdef CONV_ACC_RELU_EN
  localparam int SAT_NEG = 0;
`else
  localparam int SAT_NEG = -128;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               din_valid = 1'b0;
  logic signed [17:0] din = '0;
  logic signed [31:0] bias = '0;
  logic        [4:0]  shift = '0;
  logic               dout_valid;
  logic signed [7:0]  dout;
  logic               frame_done;
  logic        [1:0]  ch_cnt;
  logic        [8:0]  pix_cnt;

  int checks = 0;
  int passed = 0;
  int n_valid = 0;
  int n_fd = 0;
  int fd_bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  longint     m_acc;
  int         m_ch;
  int         m_pix;

  always #5 clk = ~clk;

  conv_acc_requant #(.NUM_CH(NUM_CH), .ACC_W(32), .OUT_PIX(OUT_PIX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .din_valid  (din_valid),
    .din        (din),
    .bias       (bias),
    .shift      (shift),
    .dout_valid (dout_valid),
    .dout       (dout),
    .frame_done (frame_done),
    .ch_cnt     (ch_cnt),
    .pix_cnt    (pix_cnt)
  );

  always @(negedge clk) begin
    if (dout_valid) begin
      obs_q.push_back({frame_done, dout});
      n_valid++;
      if (frame_done) n_fd++;
    end else if (frame_done) begin
      fd_bad++;
    end
  end

  function automatic logic signed [7:0] requant(input longint s, input int sh);
    longint t;
    t = (s + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0))) >>> sh;
`ifdef CONV_ACC_RELU_EN
    if (t < 0) return 8'sh00;
`else
    if (t < -128) return 8'sh80;
`endif
    if (t > 127) return 8'sh7f;
    return 8'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ch  = 0;
    m_pix = 0;
  endtask

  // A pixel's result is the 32-bit wrapped sum of its beats plus the last beat's bias.
  task automatic model_beat(input int d, input int b, input int s);
    if (m_ch == NUM_CH - 1) begin
      exp_q.push_back({(m_pix == OUT_PIX - 1), requant(longint'(int'(m_acc + d + b)), s)});
      m_acc = 0;
      m_ch  = 0;
      m_pix = (m_pix + 1) % OUT_PIX;
    end else begin
      m_acc = m_acc + d;
      m_ch++;
    end
  endtask

  task automatic cyc(input logic v, input int d, input int b, input int s);
    din_valid = v;
    din       = 18'(d);
    bias      = b;
    shift     = 5'(s);
    @(negedge clk);
    if (v && !clear && rst_n) model_beat(d, b, s);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    int n;
    idle(3);
    chk({tag, " count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset dout_valid", dout_valid, 0);
    chk("reset dout", dout, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset ch_cnt", ch_cnt, 0);
    chk("reset pix_cnt", pix_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    cyc(1'b1, 100, 6, 2);
    chk("ch_cnt after beat0", ch_cnt, 1);
    cyc(1'b1, 200, 6, 2);
    cyc(1'b1, -50, 6, 2);
    chk("ch_cnt wrap", ch_cnt, 0);
    chk("no output at edge N", dout_valid, 0);
    idle(1);
    chk("dout_valid at edge N+1", dout_valid, 1);
    chk("basic dout", dout, 64);
    chk("basic frame_done", frame_done, 0);
    chk("pix_cnt after pixel", pix_cnt, 1);
    idle(1);
    chk("dout_valid one cycle", dout_valid, 0);
    drain("basic");

    repeat (3) cyc(1'b1, 131071, 0, 0);
    idle(1);
    chk("sat positive", dout, 127);
    repeat (3) cyc(1'b1, -131072, 0, 0);
    idle(1);
    chk("sat negative", dout, SAT_NEG);
    drain("sat");

    cyc(1'b1, -6, 0, 2); cyc(1'b1, 0, 0, 2); cyc(1'b1, 0, 0, 2);
    idle(1);
    chk("round -6>>2", dout, (SAT_NEG == 0) ? 0 : -1);
    cyc(1'b1, -3, 0, 2); cyc(1'b1, -4, 0, 2); cyc(1'b1, 0, 0, 2);
    idle(1);
    chk("round -7>>2", dout, (SAT_NEG == 0) ? 0 : -2);
    drain("round");

    for (int p = 0; p < 120; p++) begin
      automatic int b;
      automatic int s;
      if ($urandom_range(0, 1) == 1) begin
        b = int'($urandom_range(0, 4000)) - 2000;
        s = int'($urandom_range(0, 12));
      end else begin
        b = int'($urandom);
        s = int'($urandom_range(0, 31));
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (k == NUM_CH - 1)
          cyc(1'b1, int'($urandom_range(0, 262143)) - 131072, b, s);
        else
          cyc(1'b1, int'($urandom_range(0, 262143)) - 131072, int'($urandom), int'($urandom_range(0, 31)));
      end
    end
    drain("random");

    cyc(1'b1, 7, 0, 0); cyc(1'b1, 7, 0, 0);
    clear = 1'b1;
    cyc(1'b1, 9, 0, 0);
    clear = 1'b0;
    model_reset();
    chk("clear ch_cnt", ch_cnt, 0);
    chk("clear pix_cnt", pix_cnt, 0);
    repeat (3) cyc(1'b1, 5, 0, 0);
    idle(1);
    chk("after clear dout", dout, 15);
    drain("clear");

    repeat (3) cyc(1'b1, 5, 0, 0);
    clear = 1'b1;
    cyc(1'b0, 0, 0, 0);
    clear = 1'b0;
    model_reset();
    void'(exp_q.pop_back());
    drain("clear inflight");

    cyc(1'b1, 7, 0, 0); cyc(1'b1, 7, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst dout", dout, 0);
    chk("rst dout_valid", dout_valid, 0);
    chk("rst ch_cnt", ch_cnt, 0);
    chk("rst pix_cnt", pix_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cyc(1'b1, 5, 0, 0);
    idle(1);
    chk("after reset dout", dout, 15);
    drain("reset");

    clear = 1'b1;
    cyc(1'b0, 0, 0, 0);
    clear = 1'b0;
    model_reset();
    n_valid = 0;
    n_fd = 0;
    fd_bad = 0;
    begin
      automatic int beats = 0;
      automatic int c = 0;
      while (beats < OUT_PIX * NUM_CH) begin
        if (c % 4 == 3) begin
          cyc(1'b0, 0, 0, 0);
        end else begin
          cyc(1'b1, 1, 0, 0);
          beats++;
        end
        c++;
      end
    end
    idle(3);
    chk("stream pulses", n_valid, OUT_PIX);
    chk("stream frame_done count", n_fd, 1);
    chk("stream frame_done alone", fd_bad, 0);
    chk("stream pix_cnt wrap", pix_cnt, 0);
    drain("stream");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/conv_acc_requant.md
# conv_acc_requant

Output stage of the convolution datapath, directly downstream of the 9-input INT8 adder tree. It accumulates the adder tree's 18-bit partial sums across `NUM_CH` input channels for one output pixel, then adds a per-filter bias. The result is requantised with a rounding arithmetic shift, optionally rectified, and saturated to INT8. A pixel counter flags the last pixel of each output feature map.

## Interface
Parameters:
- `NUM_CH`, 3: partial sums (input channels) accumulated per output pixel; ≥1.
- `ACC_W`, 32: accumulator and bias width; ≥18.
- `OUT_PIX`, 480: output pixels per feature map; ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort; zeroes accumulator, channel and pixel counters.
- `din_valid` input 1: `din` is valid this cycle (one beat).
- `din` input 18 signed: adder-tree partial sum.
- `bias` input `ACC_W` signed: sampled on the last channel beat.
- `shift` input 5: requant right-shift amount, 0–31; sampled on the last channel beat.
- `dout_valid` output 1: one-cycle pulse, `dout` valid.
- `dout` output 8 signed: requantised pixel.
- `frame_done` output 1: pulses with `dout_valid` on pixel `OUT_PIX`-1.
- `ch_cnt` output `$clog2(NUM_CH)` (min 1): current channel index.
- `pix_cnt` output `$clog2(OUT_PIX)` (min 1): index of the next pixel to be emitted.

## Operation
- Stage A, accumulate, on each edge with `din_valid`=1:
  - `ch_cnt` < `NUM_CH`-1: `acc` <= `acc` + sext(`din`); `ch_cnt` increments.
  - `ch_cnt` = `NUM_CH`-1 (last beat):
    - `sum_r` <= `acc` + sext(`din`) + `bias`; `sh_r` <= `shift`.
    - `acc` <= 0; `ch_cnt` <= 0; `stb_r` <= 1.
  - Otherwise `stb_r` <= 0.
  - `din_valid`=0 beats are holes: no state change except `stb_r` <= 0.
- Stage B, requantise, on an edge with `stb_r`=1:
  - `t` = (`sum_r` + (`sh_r`>0 ? 1<<(`sh_r`-1) : 0)) >>> `sh_r`, computed at `ACC_W`+1 bits so the rounding add cannot wrap.
  - `dout` <= saturate(`t`) to [-128,127].
  - `dout_valid` <= 1.
  - `frame_done` <= (`pix_cnt`=`OUT_PIX`-1).
  - `pix_cnt` increments, wrapping to 0 after `OUT_PIX`-1.
- Arithmetic:
  - `acc` and `sum_r` wrap modulo 2^`ACC_W`; no overflow detection.
  - All arithmetic is two's complement and signed.
- `NUM_CH`=1: every valid beat is a last beat.

## Timing
- Reset values (`rst_n`=0, immediate): `acc`=0, `ch_cnt`=0, `pix_cnt`=0, `sum_r`=0, `stb_r`=0, `dout`=0, `dout_valid`=0, `frame_done`=0.
- Latency: the last beat is sampled at edge N; `dout_valid`, `dout` and `frame_done` are registered at edge N+1 and visible for one cycle. This is 2 cycles from the beat's presentation to output.
- Throughput: one beat per cycle sustained. Back-to-back pixels need no gap, because `acc` is cleared in the same edge that captures `sum_r`.
- No backpressure: the consumer must accept every `dout_valid` pulse.
- `clear` and `din_valid` in the same cycle: `clear` wins and the beat is dropped. `clear` also drops an in-flight `stb_r`, so no output follows.
- `rst_n` asserted mid-pixel: partial sum discarded. After release, the first beat counts as channel 0.
- `frame_done` is asserted only together with `dout_valid`.

## Configuration
- `CONV_ACC_RELU_EN`:
  - Defined: the saturation range becomes [0,127]; negative `t` yields `dout`=0.
  - Undefined: signed saturation to [-128,127].
- No other behaviour or latency changes.

## Test plan
- Defaults without ReLU:
  - Stimulus: `din`=100,200,-50 in consecutive cycles, `bias`=6, `shift`=2.
  - Response: sum 256, rounding gives (256+2)>>>2=64, so `dout`=64, one cycle after the third beat edge.
- Saturation:
  - Stimulus: `din`=131071 ×3, `bias`=0, `shift`=0.
  - Response: `dout`=127.
  - Stimulus: `din`=-131072 ×3.
  - Response: `dout`=-128, or 0 with `CONV_ACC_RELU_EN`.
- Rounding of negatives:
  - Stimulus: sum -6, `shift`=2.
  - Response: (-6+2)>>>2 = -1, so `dout`=-1.
  - Stimulus: sum -7, `shift`=2.
  - Response: -5>>>2 = -2, so `dout`=-2.
- Streaming with holes:
  - Stimulus: 480×3 beats of `din`=1, `bias`=0, `shift`=0, with `din_valid` low every 4th cycle.
  - Response: 480 `dout_valid` pulses of value 3; `frame_done` only on the 480th; `pix_cnt` back to 0.
- Abort and reset:
  - Stimulus: 2 beats, then `clear`, then 3 beats of `din`=5.
  - Response: `dout`=15.
  - Stimulus: repeat with `rst_n` pulsed low after 2 beats.
  - Response: same result, `dout`=15; all outputs read 0 while `rst_n` is low.
